ppe_pipe_param: RTL and testbench

PPE_PIPE_PARAM -- requirements
Module: ppe_pipe_param

---
 rtl/ppe_pipe_param.sv | 87 ++++++++
 tb/tb_ppe_pipe_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ppe_pipe_param.sv
// ppe_pipe_param: two-stage pipelined wrap-around priority encoder with valid/ready handshake.
// Define PPE_PIPE_RR_MODE_EN to replace p_enc with an internal round-robin pointer.
module ppe_pipe_param #(
    parameter int W  = 512,
    parameter int LW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  req,
    input  logic [LW-1:0] p_enc,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [LW-1:0] o_value,
    output logic [LW-1:0] o_value_inc,
    output logic          o_any,
    output logic          out_valid,
    input  logic          out_ready
);
    logic          a_valid;
    logic [W-1:0]  a_req;
    logic          b_adv;
    logic          a_adv;
    logic [LW-1:0] p;
    logic [2*W-1:0] dbl;
    logic [W-1:0]  rot;
    logic [LW-1:0] idx;
    logic          any;
    logic [LW-1:0] gnt;
    logic [LW-1:0] gnt_inc;

    assign b_adv    = !out_valid || out_ready;
    assign a_adv    = !a_valid || b_adv;
    assign in_ready = a_adv;

`ifdef PPE_PIPE_RR_MODE_EN
    logic [LW-1:0] ptr;
    assign p = ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (b_adv && a_valid && any) ptr <= gnt_inc;
    end
`else
    logic [LW-1:0] a_p;
    assign p = a_p;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) a_p <= '0;
        else if (in_valid && a_adv) a_p <= p_enc;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_req   <= '0;
        end else if (a_adv) begin
            a_valid <= in_valid;
            if (in_valid) a_req <= req;
        end
    end

    // Rotate so index p lands at bit 0, then the lowest set bit is the grant offset.
    always_comb begin
        dbl = {a_req, a_req} >> p;
        rot = dbl[W-1:0];
        idx = '0;
        for (int i = W - 1; i >= 0; i--) if (rot[i]) idx = LW'(i);
        any     = |a_req;
        gnt     = any ? p + idx : '0;
        gnt_inc = gnt + LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            o_value     <= '0;
            o_value_inc <= '0;
            o_any       <= 1'b0;
        end else if (b_adv) begin
            out_valid <= a_valid;
            if (a_valid) begin
                o_value     <= gnt;
                o_value_inc <= gnt_inc;
                o_any       <= any;
            end
        end
    end
endmodule

// File: tb/tb_ppe_pipe_param.sv
// tb_ppe_pipe_param: directed self-checking bench for ppe_pipe_param (W=512).
module tb_ppe_pipe_param;
    localparam int W  = 512;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  req = '0;
    logic [LW-1:0] p_enc = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LW-1:0] o_value;
    logic [LW-1:0] o_value_inc;
    logic          o_any;
    logic          out_valid;
    logic          out_ready = 1'b1;
    int checks = 0;
    int errors = 0;

    ppe_pipe_param #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .p_enc(p_enc), .in_valid(in_valid),
        .in_ready(in_ready), .o_value(o_value), .o_value_inc(o_value_inc),
        .o_any(o_any), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_check(input string name, input logic [W-1:0] r, input int p,
                                  input int ev, input int einc, input logic eany);
        req = r; p_enc = LW'(p); in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early out_valid=%b required 0", name, out_valid); end
        step();
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid=%b required 1", name, out_valid); end
        if (o_value !== LW'(ev)) begin errors++; $display("FAIL %s o_value=%0d required %0d", name, o_value, ev); end
        if (o_value_inc !== LW'(einc)) begin errors++; $display("FAIL %s o_value_inc=%0d required %0d", name, o_value_inc, einc); end
        if (o_any !== eany) begin errors++; $display("FAIL %s o_any=%b required %b", name, o_any, eany); end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid=%b required 0", out_valid); end
        if (o_value !== '0) begin errors++; $display("FAIL reset o_value=%0d required 0", o_value); end
        if (o_value_inc !== '0) begin errors++; $display("FAIL reset o_value_inc=%0d required 0", o_value_inc); end
        if (o_any !== 1'b0) begin errors++; $display("FAIL reset o_any=%b required 0", o_any); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready=%b required 1", in_ready); end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [W-1:0] r;
        r = '0; r[5] = 1'b1; r[300] = 1'b1;
        send_and_check("basic", r, 100, 300, 301, 1'b1);
    endtask

    task automatic test_wrap();
        logic [W-1:0] r;
        r = '0; r[0] = 1'b1;
        send_and_check("wrap_to_0", r, 511, 0, 1, 1'b1);
        r = '0; r[511] = 1'b1;
        send_and_check("inc_wrap", r, 511, 511, 0, 1'b1);
    endtask

    task automatic test_zero();
        send_and_check("zero_req", '0, 37, 0, 1, 1'b0);
    endtask

    task automatic test_priority();
        logic [W-1:0] r;
        r = '0; r[10] = 1'b1; r[200] = 1'b1; r[201] = 1'b1;
        send_and_check("start_wins", r, 200, 200, 201, 1'b1);
        send_and_check("scan_up", r, 202, 10, 11, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vec [4];
        int pv [4];
        int ev [4];
        int sent = 0;
        int rcv = 0;
        logic held = 1'b0;
        logic saw_stall = 1'b0;
        logic [LW-1:0] held_val = '0;
        for (int k = 0; k < 4; k++) vec[k] = '0;
        vec[0][3] = 1'b1;                   pv[0] = 0;  ev[0] = 3;
        vec[1][10] = 1'b1; vec[1][20] = 1'b1; pv[1] = 15; ev[1] = 20;
        vec[2][511] = 1'b1;                 pv[2] = 0;  ev[2] = 511;
        vec[3][0] = 1'b1; vec[3][1] = 1'b1; pv[3] = 1;  ev[3] = 1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = (sent < 4);
            req = vec[sent < 4 ? sent : 3];
            p_enc = LW'(pv[sent < 4 ? sent : 3]);
            out_ready = !(cyc >= 3 && cyc <= 5);
            #2;
            if (!in_ready) saw_stall = 1'b1;
            if (held) begin
                checks += 2;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold out_valid=%b required 1", out_valid); end
                if (o_value !== held_val) begin errors++; $display("FAIL b2b_hold o_value=%0d required %0d", o_value, held_val); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (rcv >= 4) begin errors++; $display("FAIL b2b_extra result o_value=%0d required none", o_value); end
                else if (o_value !== LW'(ev[rcv])) begin errors++; $display("FAIL b2b_result%0d o_value=%0d required %0d", rcv, o_value, ev[rcv]); end
                rcv++;
            end
            held = out_valid && !out_ready;
            held_val = o_value;
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks += 2;
        if (rcv != 4) begin errors++; $display("FAIL b2b_count received=%0d required 4", rcv); end
        if (!saw_stall) begin errors++; $display("FAIL b2b_stall in_ready_dropped=0 required 1"); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r;
        r = '0; r[42] = 1'b1;
        req = r; p_enc = '0; in_valid = 1'b1; out_ready = 1'b0;
        step(); in_valid = 1'b0; step();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre out_valid=%b required 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async out_valid=%b required 0", out_valid); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        r = '0; r[77] = 1'b1;
        send_and_check("midrst_after", r, 0, 77, 78, 1'b1);
    endtask

`ifdef PPE_PIPE_RR_MODE_EN
    task automatic test_rr();
        logic [W-1:0] r;
        int ev [4] = '{1, 4, 7, 1};
        int rcv = 0;
        r = '0; r[1] = 1'b1; r[4] = 1'b1; r[7] = 1'b1;
        req = r; p_enc = 9'd300; out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = (cyc < 4);
            #2;
            if (out_valid && rcv < 4) begin
                checks++;
                if (o_value !== LW'(ev[rcv])) begin errors++; $display("FAIL rr_seq%0d o_value=%0d required %0d", rcv, o_value, ev[rcv]); end
                rcv++;
            end
            step();
        end
        checks++;
        if (rcv != 4) begin errors++; $display("FAIL rr_count received=%0d required 4", rcv); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PPE_PIPE_RR_MODE_EN
        test_rr();
`else
        test_basic();
        test_wrap();
        test_zero();
        test_priority();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
